// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants and types for the tile compositor.
//   TILE_SIZE / TILE_SHIFT : tile edge length in pixels and its log2
//   ENTRY_*                : bit positions of fields in a 16-bit map entry
//   REG_ENABLE / REG_BG    : fixed cfg register addresses
//   state_t                : pixel-walk FSM states
package gpu_pkg;

  localparam int TILE_SIZE  = 8;
  localparam int TILE_SHIFT = 3;

  localparam int ENTRY_CODE_LSB = 0;
  localparam int ENTRY_CODE_W   = 8;
  localparam int ENTRY_HFLIP    = 8;
  localparam int ENTRY_VFLIP    = 9;

  localparam logic [3:0] REG_ENABLE = 4'd14;
  localparam logic [3:0] REG_BG     = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAP,
    ST_TILE,
    ST_MIX
  } state_t;

endpackage

// File: rtl/gpu_layer_regs.sv
// gpu_layer_regs: CPU-written layer registers plus an accept-time snapshot.
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data : register write port
//   snap                     : copy live registers into the snapshot this cycle
//   snap_scroll_x/_y         : per-layer scroll snapshot
//   snap_enable, snap_bg     : layer enable mask and background snapshot
// The snapshot copies the live values as they stand before any write issued
// in the same cycle, so a write coincident with an accept lands on the next pixel.
module gpu_layer_regs
  import gpu_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int SX_W       = 7,
  parameter int SY_W       = 6
)(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_we,
  input  logic [3:0]                            cfg_addr,
  input  logic [7:0]                            cfg_data,
  input  logic                                  snap,
  output logic [NUM_LAYERS-1:0][SX_W-1:0]       snap_scroll_x,
  output logic [NUM_LAYERS-1:0][SY_W-1:0]       snap_scroll_y,
  output logic [NUM_LAYERS-1:0]                 snap_enable,
  output logic [7:0]                            snap_bg
);

  logic [NUM_LAYERS-1:0] enable_reg;
  logic [7:0]            bg_reg;
  logic [NUM_LAYERS-1:0] snap_enable_reg;
  logic [7:0]            snap_bg_reg;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    logic [SX_W-1:0] scroll_x_reg;
    logic [SY_W-1:0] scroll_y_reg;
    logic [SX_W-1:0] snap_x_reg;
    logic [SY_W-1:0] snap_y_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        scroll_x_reg <= '0;
        scroll_y_reg <= '0;
        snap_x_reg   <= '0;
        snap_y_reg   <= '0;
      end else begin
        if (cfg_we && cfg_addr == 4'(2*gi))
          scroll_x_reg <= SX_W'(cfg_data);
        if (cfg_we && cfg_addr == 4'(2*gi+1))
          scroll_y_reg <= SY_W'(cfg_data);
        if (snap) begin
          snap_x_reg <= scroll_x_reg;
          snap_y_reg <= scroll_y_reg;
        end
      end
    end

    assign snap_scroll_x[gi] = snap_x_reg;
    assign snap_scroll_y[gi] = snap_y_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_reg      <= '1;
      bg_reg          <= '0;
      snap_enable_reg <= '1;
      snap_bg_reg     <= '0;
    end else begin
      if (cfg_we && cfg_addr == REG_ENABLE)
        enable_reg <= cfg_data[NUM_LAYERS-1:0];
      if (cfg_we && cfg_addr == REG_BG)
        bg_reg <= cfg_data;
      if (snap) begin
        snap_enable_reg <= enable_reg;
        snap_bg_reg     <= bg_reg;
      end
    end
  end

  assign snap_enable = snap_enable_reg;
  assign snap_bg     = snap_bg_reg;

endmodule

// File: rtl/tile_compositor.sv
// tile_compositor: per-pixel multi-layer tilemap renderer.
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data : layer register writes (scroll, enable, bg)
//   pixel_req/pixel_addr     : pixel request, linear index y*SCREEN_W+x
//   pixel_ready              : idle, request accepted when req && ready
//   pixel_valid/pixel_data   : one-cycle result pulse and composited colour
//   vram_addr/vram_q         : map entry read (1-cycle latency)
//   rom_addr/rom_q           : tile pixel read (1-cycle latency)
// Each layer takes MAP -> TILE -> MIX; layers are walked bottom to top and a
// non-zero enabled pixel overwrites the accumulated colour.
module tile_compositor
  import gpu_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int MAP_COLS   = 16,
  parameter int MAP_ROWS   = 8,
  parameter int SCREEN_W   = 128,
  parameter int SCREEN_H   = 64,
  localparam int PA_W = $clog2(SCREEN_W*SCREEN_H),
  localparam int VA_W = $clog2(NUM_LAYERS*MAP_COLS*MAP_ROWS),
  localparam int SX_W = $clog2(MAP_COLS*TILE_SIZE),
  localparam int SY_W = $clog2(MAP_ROWS*TILE_SIZE)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_addr,
  input  logic [7:0]      cfg_data,
  input  logic            pixel_req,
  input  logic [PA_W-1:0] pixel_addr,
  output logic            pixel_ready,
  output logic            pixel_valid,
  output logic [7:0]      pixel_data,
  output logic [VA_W-1:0] vram_addr,
  input  logic [15:0]     vram_q,
  output logic [13:0]     rom_addr,
  input  logic [7:0]      rom_q
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = PA_W - XW;
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  state_t          state_reg, state_next;
  logic [LW-1:0]   layer_reg, layer_next;
  logic [XW-1:0]   x_reg, x_next;
  logic [YW-1:0]   y_reg, y_next;
  logic [7:0]      acc_reg, acc_next;
  logic [7:0]      pixel_data_reg, pixel_data_next;

  logic [NUM_LAYERS-1:0][SX_W-1:0] snap_scroll_x;
  logic [NUM_LAYERS-1:0][SY_W-1:0] snap_scroll_y;
  logic [NUM_LAYERS-1:0]           snap_enable;
  logic [7:0]                      snap_bg;

  logic accept;
  assign pixel_ready = (state_reg == ST_IDLE) && !rst;
  assign accept      = pixel_req && pixel_ready;

  gpu_layer_regs #(
    .NUM_LAYERS (NUM_LAYERS),
    .SX_W       (SX_W),
    .SY_W       (SY_W)
  ) u_regs (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .snap          (accept),
    .snap_scroll_x (snap_scroll_x),
    .snap_scroll_y (snap_scroll_y),
    .snap_enable   (snap_enable),
    .snap_bg       (snap_bg)
  );

  // Scrolled map coordinates; the layer index is stable across MAP/TILE/MIX,
  // so these are recomputed each cycle instead of being registered.
  logic [SX_W-1:0]    sx;
  logic [SY_W-1:0]    sy;
  logic [VA_W-1:0]    vram_addr_calc;
  logic [13:0]        rom_addr_calc;
  logic [2:0]         tile_col, tile_row;
  logic [7:0]         mix_base, mixed;

  always_comb begin
    sx = SX_W'(x_reg) + snap_scroll_x[layer_reg];
    sy = SY_W'(y_reg) + snap_scroll_y[layer_reg];
    vram_addr_calc = VA_W'(int'(layer_reg) * (MAP_COLS*MAP_ROWS)
                         + int'(sy[SY_W-1:TILE_SHIFT]) * MAP_COLS
                         + int'(sx[SX_W-1:TILE_SHIFT]));
    tile_col = sx[TILE_SHIFT-1:0] ^ {3{vram_q[ENTRY_HFLIP]}};
    tile_row = sy[TILE_SHIFT-1:0] ^ {3{vram_q[ENTRY_VFLIP]}};
    rom_addr_calc = {vram_q[ENTRY_CODE_LSB +: ENTRY_CODE_W], tile_row, tile_col};
    // Layer 0 starts from the snapshotted background rather than a value
    // preloaded at accept, since the snapshot only becomes visible after it.
    mix_base = (layer_reg == '0) ? snap_bg : acc_reg;
    mixed    = (snap_enable[layer_reg] && rom_q != 8'h00) ? rom_q : mix_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      layer_reg      <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      acc_reg        <= '0;
      pixel_data_reg <= '0;
    end else begin
      state_reg      <= state_next;
      layer_reg      <= layer_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      acc_reg        <= acc_next;
      pixel_data_reg <= pixel_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    layer_next      = layer_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    acc_next        = acc_reg;
    pixel_data_next = pixel_data_reg;
    pixel_valid     = 1'b0;
    pixel_data      = pixel_data_reg;
    vram_addr       = '0;
    rom_addr        = '0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          x_next     = pixel_addr[XW-1:0];
          y_next     = pixel_addr[PA_W-1:XW];
          layer_next = '0;
          state_next = ST_MAP;
        end
      end
      ST_MAP: begin
        vram_addr  = vram_addr_calc;
        state_next = ST_TILE;
      end
      ST_TILE: begin
        rom_addr   = rom_addr_calc;
        state_next = ST_MIX;
      end
      ST_MIX: begin
        acc_next = mixed;
        if (layer_reg == LAST_LAYER) begin
          pixel_valid     = 1'b1;
          pixel_data      = mixed;
          pixel_data_next = mixed;
          state_next      = ST_IDLE;
        end else begin
          layer_next = layer_reg + LW'(1);
          state_next = ST_MAP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Outputs read as zero for the whole time reset is held.
    if (rst) begin
      pixel_valid = 1'b0;
      pixel_data  = '0;
      vram_addr   = '0;
      rom_addr    = '0;
    end
  end

endmodule
